// File: rtl/branch_hazard_ctrl_pkg.sv
// Shared constants and types for the ID-stage branch hazard controller.
// Opcode/funct values, pc_sel and branch_code encodings, FSM states.
package branch_hazard_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] OP_BNE     = 6'b000101;
  localparam logic [5:0] FN_JR      = 6'b001000;
  localparam logic [5:0] FN_JALR    = 6'b001001;

  localparam logic [1:0] PC_SEL_SEQ  = 2'b00;
  localparam logic [1:0] PC_SEL_BR   = 2'b01;
  localparam logic [1:0] PC_SEL_JMP  = 2'b10;
  localparam logic [1:0] PC_SEL_JALR = 2'b11;

  localparam logic [1:0] BC_NONE  = 2'b00;
  localparam logic [1:0] BC_TAKEN = 2'b01;
  localparam logic [1:0] BC_JUMP  = 2'b10;
  localparam logic [1:0] BC_JALR  = 2'b11;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/branch_hazard_ctrl_src_decode.sv
// branch_src_decode: which source registers the ID-stage branch reads.
// beq/bne read rs and rt; jr/jalr read rs; everything else reads none.
module branch_src_decode
  import branch_hazard_ctrl_pkg::*;
(
  input  logic [31:0] id_inst,
  output logic        use_rs,
  output logic        use_rt,
  output logic [4:0]  rs,
  output logic [4:0]  rt
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       is_br;
  logic       is_jr;
  logic       unused_imm;

  assign op = id_inst[31:26];
  assign fn = id_inst[5:0];
  assign rs = id_inst[25:21];
  assign rt = id_inst[20:16];
  assign unused_imm = ^id_inst[15:6];

  assign is_br = (op == OP_BEQ) || (op == OP_BNE);
  assign is_jr = (op == OP_SPECIAL) &&
                 ((fn == FN_JR) || (fn == FN_JALR));

  // Map instruction class to register-use flags.
  always_comb begin
    use_rs = 1'b0;
    use_rt = 1'b0;
    unique case (1'b1)
      is_br: begin
        use_rs = 1'b1;
        use_rt = 1'b1;
      end
      is_jr: use_rs = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard stall FSM and PC/pipeline redirect control.
// Define BRANCH_DELAY_SLOT_EN to keep the delay-slot instruction (no flush).
module branch_hazard_ctrl
  import branch_hazard_ctrl_pkg::*;
#(
  parameter int unsigned STALL_LOAD_EX  = 2,
  parameter int unsigned STALL_ALU_EX   = 1,
  parameter int unsigned STALL_LOAD_MEM = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_inst,
  input  logic [1:0]  branch_code,
  input  logic        ex_regwrite,
  input  logic        ex_memread,
  input  logic [4:0]  ex_rd,
  input  logic        mem_memread,
  input  logic [4:0]  mem_rd,
  input  logic        ext_stall,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        busy
);

  localparam logic [1:0] N_LEX = 2'(STALL_LOAD_EX);
  localparam logic [1:0] N_ALU = 2'(STALL_ALU_EX);
  localparam logic [1:0] N_LM  = 2'(STALL_LOAD_MEM);

  logic       use_rs;
  logic       use_rt;
  logic [4:0] rs;
  logic [4:0] rt;

  branch_src_decode u_dec (
    .id_inst (id_inst),
    .use_rs  (use_rs),
    .use_rt  (use_rt),
    .rs      (rs),
    .rt      (rt)
  );

  logic       ex_hit;
  logic       mem_hit;
  logic [1:0] need;

  assign ex_hit =
    (use_rs && rs != 5'd0 && rs == ex_rd) ||
    (use_rt && rt != 5'd0 && rt == ex_rd);
  assign mem_hit =
    (use_rs && rs != 5'd0 && rs == mem_rd) ||
    (use_rt && rt != 5'd0 && rt == mem_rd);

  // Largest stall demanded by any matching producer.
  always_comb begin
    need = 2'd0;
    if (ex_hit && ex_memread && N_LEX > need)
      need = N_LEX;
    if (ex_hit && ex_regwrite && !ex_memread && N_ALU > need)
      need = N_ALU;
    if (mem_hit && mem_memread && N_LM > need)
      need = N_LM;
  end

  state_t     state, state_n;
  logic [1:0] cnt, cnt_n;

  // State and remaining-hold counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_RUN;
      cnt   <= 2'd0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  logic       pw_c;
  logic [1:0] sel_c;
  logic       iw_c;
  logic       fl_c;
  logic       bub_c;

  // Next state and stall/redirect outputs; ext_stall freezes all.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    pw_c    = 1'b0;
    sel_c   = PC_SEL_SEQ;
    iw_c    = 1'b0;
    fl_c    = 1'b0;
    bub_c   = 1'b0;
    if (!ext_stall) begin
      if (state == ST_HOLD) begin
        bub_c = 1'b1;
        cnt_n = cnt - 2'd1;
        if (cnt <= 2'd1)
          state_n = ST_RUN;
      end else if (need != 2'd0) begin
        bub_c = 1'b1;
        if (need > 2'd1) begin
          state_n = ST_HOLD;
          cnt_n   = need - 2'd1;
        end
      end else begin
        pw_c  = 1'b1;
        iw_c  = 1'b1;
        sel_c = branch_code;
`ifdef BRANCH_DELAY_SLOT_EN
        fl_c  = 1'b0;
`else
        fl_c  = (branch_code != BC_NONE);
`endif
      end
    end
  end

  assign pc_write    = rst_n & pw_c;
  assign pc_sel      = rst_n ? sel_c : PC_SEL_SEQ;
  assign ifid_write  = rst_n & iw_c;
  assign ifid_flush  = rst_n & fl_c;
  assign idex_bubble = rst_n & bub_c;
  assign busy        = rst_n & (state == ST_HOLD);

endmodule
